// File: rtl/seq_mul_unsigned.sv
// ---------------------------------------------------------------------------
// seq_mul_unsigned
//   Iterative radix-2 shift-and-add multiplier for unsigned operands.
//   Operands come in over a valid/ready handshake. The block then iterates
//   once per multiplier bit and returns the full-width product over a second
//   valid/ready handshake. Only one operation is in flight at a time.
//
//   Optional feature macro: SEQ_MUL_EARLY_EXIT_EN
//     When defined, iteration stops as soon as no set multiplier bits remain,
//     so latency tracks the multiplier's MSB position. The product is the same
//     either way.
//
// Parameters
//   WIDTH_A      multiplicand width (>= 1)
//   WIDTH_B      multiplier width (>= 1), sets the iteration count
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset
//   in_valid_i   operands valid
//   in_ready_o   block can accept operands (IDLE only)
//   a_i          multiplicand
//   b_i          multiplier
//   out_valid_o  product valid (DONE)
//   out_ready_i  consumer accepts product
//   prod_o       WIDTH_A+WIDTH_B bit product, driven from the accumulator
//   busy_o       high in BUSY or DONE
// ---------------------------------------------------------------------------
module seq_mul_unsigned #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_B = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH_A-1:0]         a_i,
    input  logic [WIDTH_B-1:0]         b_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH_A+WIDTH_B-1:0] prod_o,
    output logic                       busy_o
);

    // Index width for a count of n items. A minimum of 1 bit is kept so the
    // counter always has a legal width.
    function automatic int idx_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int PW = WIDTH_A + WIDTH_B;
    localparam int CW = idx_width(WIDTH_B);

`ifndef SYNTHESIS
    generate
        if (WIDTH_A < 1) begin : g_bad_wa
            $fatal(1, "seq_mul_unsigned: WIDTH_A must be >= 1");
        end
        if (WIDTH_B < 1) begin : g_bad_wb
            $fatal(1, "seq_mul_unsigned: WIDTH_B must be >= 1");
        end
    endgenerate
`endif

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      acc_q,   acc_d;
    logic [PW-1:0]      a_sh_q,  a_sh_d;
    logic [WIDTH_B-1:0] b_sh_q,  b_sh_d;
    logic [CW-1:0]      cnt_q,   cnt_d;

    logic last_iter;

    // The final iteration is the one that consumes the top multiplier bit.
    // With early exit, it may also be the one after which no set bits remain.
`ifdef SEQ_MUL_EARLY_EXIT_EN
    assign last_iter = (cnt_q == CW'(WIDTH_B - 1)) || ((b_sh_q >> 1) == '0);
`else
    assign last_iter = (cnt_q == CW'(WIDTH_B - 1));
`endif

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    a_sh_d  = PW'(a_i);
                    b_sh_d  = b_i;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Wraps modulo 2^PW. No carry is lost for in-range operands
                // because the product fits in PW bits.
                if (b_sh_q[0]) begin
                    acc_d = acc_q + a_sh_q;
                end
                a_sh_d = a_sh_q << 1;
                b_sh_d = b_sh_q >> 1;
                cnt_d  = cnt_q + CW'(1);
                if (last_iter) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                // Hold the result until the consumer takes it. No new operands
                // are accepted here, so the accept always lands in IDLE.
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready_o  = (state_q == S_IDLE);
    assign out_valid_o = (state_q == S_DONE);
    assign busy_o      = (state_q != S_IDLE);
    assign prod_o      = acc_q;

endmodule

// File: doc/seq_mul_unsigned.md
# seq_mul_unsigned

Iterative radix-2 shift-and-add multiplier for natural numbers. It is the runtime, inverse-direction counterpart of the elaboration-time division helpers in `cf_math_pkg`: it computes `a * b` in hardware over several cycles instead of `ceil_div` at elaboration. It sits in the core's multi-cycle arithmetic path, taking operands over a valid/ready handshake and returning a full-width product over a second valid/ready handshake.

## Interface
- `WIDTH_A`, default 32: multiplicand width, must be ≥ 1.
- `WIDTH_B`, default 32: multiplier width, must be ≥ 1. It sets the iteration count.
- `clk_i`, input, 1: single clock; all state updates on its rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `in_valid_i`, input, 1: operands valid.
- `in_ready_o`, output, 1: block can accept operands.
- `a_i`, input, WIDTH_A: multiplicand, unsigned.
- `b_i`, input, WIDTH_B: multiplier, unsigned.
- `out_valid_o`, output, 1: product valid.
- `out_ready_i`, input, 1: consumer accepts product.
- `prod_o`, output, WIDTH_A+WIDTH_B: unsigned product.
- `busy_o`, output, 1: high in BUSY or DONE.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- **IDLE**
  - `in_ready_o`=1.
  - On `in_valid_i`=1 (an accept):
    - load `a_sh` = zero-extended `a_i` (WIDTH_A+WIDTH_B bits);
    - load `b_sh` = `b_i`;
    - clear `acc` to 0 and `cnt` to 0;
    - go to BUSY.
- **BUSY** (`in_ready_o`=0). Each cycle:
  - if `b_sh[0]`, `acc` += `a_sh`; the addition is modulo 2^(WIDTH_A+WIDTH_B) and never overflows for valid operands;
  - `a_sh` <<= 1, `b_sh` >>= 1, `cnt`++;
  - go to DONE when `cnt` == WIDTH_B-1 in this cycle (the final iteration), or on the early-exit condition (see Configuration).
- `cnt` width is `cf_math_pkg::idx_width(WIDTH_B)`.
- **DONE**
  - `out_valid_o`=1 and `prod_o`=`acc`, held stable until the handshake completes.
  - On `out_ready_i`=1, go to IDLE.
  - `in_ready_o`=0: no overlap between result drain and new accept.
- `prod_o` is driven from `acc` in every state. Its value is meaningful only while `out_valid_o`=1.
- Inputs `a_i`/`b_i` are sampled only on the accept edge. Later changes have no effect.
- In non-synthesis builds, WIDTH_A < 1 or WIDTH_B < 1 triggers `$fatal` at elaboration.

## Timing
- Reset values:
  - outputs: `in_ready_o`=1, `out_valid_o`=0, `prod_o`=0, `busy_o`=0;
  - internal state: IDLE, with `acc`, `a_sh`, `b_sh` and `cnt` all 0.
- Reset asserted in any state returns to the reset values on the next edge. Any in-flight operation is discarded and no `out_valid_o` is produced for it.
- Latency is measured from the accept edge to the first cycle with `out_valid_o`=1:
  - without the macro: WIDTH_B+1 cycles;
  - with the macro: max(1, msb_index(b)+1)+1 cycles, which is 2 for b=0 or b=1.
- Throughput is one result per (latency + 1) cycles when `out_ready_i` is held at 1.
- If `in_valid_i` and `out_ready_i` are both high in DONE, the new operands are not accepted that cycle. The accept happens in the following IDLE cycle.
- `out_ready_i` held low keeps DONE indefinitely, with `prod_o` stable.

## Configuration
- Macro: `SEQ_MUL_EARLY_EXIT_EN`.
- **Defined:** in BUSY, also go to DONE when the post-shift `b_sh` value (`b_sh >> 1`) is zero. BUSY always lasts at least one cycle. The product is identical; only latency shrinks.
- **Undefined:** BUSY always lasts exactly WIDTH_B cycles regardless of operand values. Latency is fixed.

## Test plan
- **Basic multiply:** a=3, b=5, `out_ready_i`=1.
  - `prod_o`=15.
  - `out_valid_o` rises 33 cycles after accept, or 4 cycles with `SEQ_MUL_EARLY_EXIT_EN`.
- **Maximum operands:** a=0xFFFFFFFF, b=0xFFFFFFFF.
  - `prod_o`=0xFFFFFFFE00000001.
  - Latency is 33 cycles in both configurations.
- **Zero operand:** b=0, a=0xDEADBEEF.
  - `prod_o`=0.
  - Latency is 33 cycles without the macro, 2 cycles with it.
  - Repeat with a=0, b=0x80000000: `prod_o`=0, latency 33 in both configurations.
- **Backpressure:** a=7, b=9, `out_ready_i`=0 for 10 cycles after `out_valid_o` rises.
  - `out_valid_o` stays 1 and `prod_o` stays 63 throughout.
  - `in_ready_o` stays 0 while `in_valid_i`=1 with new operands.
  - After `out_ready_i`=1, the block returns to IDLE and accepts next cycle.
- **Reset mid-operation:** assert `rst_i` for 1 cycle, 5 cycles after accepting a=100, b=200.
  - Next cycle: `in_ready_o`=1, `out_valid_o`=0, `prod_o`=0.
  - A following a=2, b=3 yields 6 with normal latency.
- **Back-to-back:** stream 50 random operand pairs with `in_valid_i` and `out_ready_i` held at 1.
  - Every product matches the reference model, in order.
  - There is exactly one idle cycle between each DONE and the next accept.
